// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the core datapath (master) and the hazard controller (slave):
// ID-stage instruction info and redirect in, stall/flush/forwarding controls out.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W   = 4,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3
);
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                     id_valid;
    logic                     id_wr_en;
    logic [REG_W-1:0]         id_dest;
    logic                     id_is_load;
    logic                     id_hlt;
    logic [NUM_SRC*REG_W-1:0] id_src;
    logic [NUM_SRC-1:0]       id_src_used;
    logic                     redirect;

    logic                     pc_en;
    logic                     if_id_en;
    logic                     if_id_flush;
    logic                     id_ex_flush;
    logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel;
    logic                     halted;
    logic [15:0]              stall_count;

    modport master (
        output id_valid, id_wr_en, id_dest, id_is_load, id_hlt, id_src, id_src_used, redirect,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_fwd_sel, halted, stall_count
    );

    modport slave (
        input  id_valid, id_wr_en, id_dest, id_is_load, id_hlt, id_src, id_src_used, redirect,
        output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_fwd_sel, halted, stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline control: scoreboard of EX..WB slots, registered EX forwarding selects,
// load-use stalls, redirect flushes and the HLT drain/halt sequence.
module pipe_hazard_ctrl #(
    parameter int REG_W          = 4,
    parameter int NUM_SRC        = 2,
    parameter int DEPTH          = 3,
    parameter int REDIRECT_STAGE = 1,
    parameter int LOAD_LAT       = 1,
    parameter int ZERO_REG       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_RELOAD = CNT_W'(LOAD_LAT - 1);

    typedef enum logic [1:0] { RUN, DRAIN, HALTED } state_t;

    state_t                   state;
    logic                     halted_q;
    logic [15:0]              stall_count_q;
    logic [CNT_W-1:0]         lat_cnt;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_q;

    logic             slot_vld  [DEPTH];
    logic             slot_wr   [DEPTH];
    logic [REG_W-1:0] slot_dest [DEPTH];
    logic             slot_load [DEPTH];
    logic             slot_hlt  [DEPTH];

    logic [NUM_SRC*SEL_W-1:0] fwd_sel_nxt;
    logic [REG_W-1:0]         src [NUM_SRC];
    logic                     load_use;
    logic                     stall;
    logic                     hold;
    logic                     issue;
    logic                     kill_hlt;
    logic                     hlt_retire;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        fwd_sel_nxt = '0;
        load_use    = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src[k] = bus.id_src[k*REG_W +: REG_W];
            // Scan oldest to youngest so the youngest matching slot has the last word.
            for (int j = DEPTH - 1; j >= 0; j--) begin
                if (bus.id_src_used[k] && slot_vld[j] && slot_wr[j] &&
                    (slot_dest[j] == src[k]) && !((ZERO_REG != 0) && (src[k] == '0))) begin
                    fwd_sel_nxt[k*SEL_W +: SEL_W] = (j < DEPTH - 1) ? SEL_W'(j + 1) : '0;
                    if ((j == 0) && slot_load[0] && bus.id_valid)
                        load_use = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall      = (state == RUN) && (load_use || (lat_cnt != '0));
        hold       = stall || (state != RUN);
        issue      = bus.id_valid && !bus.redirect && !hold;
        kill_hlt   = 1'b0;
        for (int j = 0; j < REDIRECT_STAGE; j++)
            kill_hlt = kill_hlt || (bus.redirect && slot_vld[j] && slot_hlt[j]);
        hlt_retire = slot_vld[DEPTH-1] && slot_hlt[DEPTH-1];
    end

    // A redirect overrides stall and drain holds, but nothing restarts a halted core.
    assign bus.pc_en       = (state != HALTED) && (bus.redirect || !hold);
    assign bus.if_id_en    = (state != HALTED) && (bus.redirect || !hold);
    assign bus.if_id_flush = bus.redirect;
    assign bus.id_ex_flush = bus.redirect || hold;
    assign bus.ex_fwd_sel  = fwd_sel_q;
    assign bus.halted      = halted_q;
    assign bus.stall_count = stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            halted_q      <= 1'b0;
            stall_count_q <= '0;
            lat_cnt       <= '0;
            fwd_sel_q     <= '0;
            for (int j = 0; j < DEPTH; j++)
                slot_vld[j] <= 1'b0;
        end else begin
            // ID -> EX boundary: the issued instruction or a bubble
            slot_vld[0] <= issue;
            fwd_sel_q   <= issue ? fwd_sel_nxt : '0;
            // EX -> MEM -> WB boundaries: slots younger than the redirecting one die
            for (int j = 1; j < DEPTH; j++)
                slot_vld[j] <= slot_vld[j-1] && !(bus.redirect && ((j - 1) < REDIRECT_STAGE));

            if (bus.redirect)
                lat_cnt <= '0;
            else if (lat_cnt != '0)
                lat_cnt <= lat_cnt - CNT_W'(1);
            else if (stall)
                lat_cnt <= LAT_RELOAD;

            if (stall && !bus.redirect)
                stall_count_q <= sat_inc16(stall_count_q);

            case (state)
                RUN: begin
                    if (issue && bus.id_hlt)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (kill_hlt) begin
                        state <= RUN;
                    end else if (hlt_retire) begin
                        state    <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload fields are qualified by slot_vld and need no reset.
    always_ff @(posedge clk) begin
        slot_wr[0]   <= bus.id_wr_en;
        slot_dest[0] <= bus.id_dest;
        slot_load[0] <= bus.id_is_load;
        slot_hlt[0]  <= bus.id_hlt;
        for (int j = 1; j < DEPTH; j++) begin
            slot_wr[j]   <= slot_wr[j-1];
            slot_dest[j] <= slot_dest[j-1];
            slot_load[j] <= slot_load[j-1];
            slot_hlt[j]  <= slot_hlt[j-1];
        end
    end
endmodule
